// File: rtl/ppg_ac_dc_extractor_pkg.sv
// Shared definitions for the PPG AC/DC extractor: FSM encoding and ADC tracker constants.
// Optional saturation flags are enabled with the PPG_SAT_FLAG_EN macro.
package ppg_pkg;

    localparam int ADC_W = 8;

    localparam logic [ADC_W-1:0] ADC_MIN_INIT = 8'd255;
    localparam logic [ADC_W-1:0] ADC_MAX_INIT = 8'd0;

    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        ACCUM  = 3'b010,
        REPORT = 3'b100
    } state_e;

endpackage

// File: rtl/ppg_ac_dc_extractor_if.sv
// Sample/result bundle between the LED controller, the extractor and the SpO2 ratio stage.
// RED_Sat/IR_Sat exist only when PPG_SAT_FLAG_EN is defined.
interface ppg_ac_dc_extractor_if #(
    parameter int CNT_W = 8
);
    logic                      Enable;
    logic                      LED_RED;
    logic                      LED_IR;
    logic [ppg_pkg::ADC_W-1:0] RED_ADC_Value;
    logic [ppg_pkg::ADC_W-1:0] IR_ADC_Value;
    logic [ppg_pkg::ADC_W-1:0] RED_AC;
    logic [ppg_pkg::ADC_W-1:0] RED_DC;
    logic [ppg_pkg::ADC_W-1:0] IR_AC;
    logic [ppg_pkg::ADC_W-1:0] IR_DC;
    logic                      Result_Valid;
    logic [CNT_W-1:0]          Pair_Count;
`ifdef PPG_SAT_FLAG_EN
    logic                      RED_Sat;
    logic                      IR_Sat;
`endif

    modport master (
        output Enable, LED_RED, LED_IR, RED_ADC_Value, IR_ADC_Value,
        input  RED_AC, RED_DC, IR_AC, IR_DC, Result_Valid, Pair_Count
`ifdef PPG_SAT_FLAG_EN
        , input RED_Sat, IR_Sat
`endif
    );

    modport slave (
        input  Enable, LED_RED, LED_IR, RED_ADC_Value, IR_ADC_Value,
        output RED_AC, RED_DC, IR_AC, IR_DC, Result_Valid, Pair_Count
`ifdef PPG_SAT_FLAG_EN
        , output RED_Sat, IR_Sat
`endif
    );

endinterface

// File: rtl/ppg_ac_dc_extractor_tracker.sv
// Per-channel min/max tracker; outputs reflect the window including the current capture.
// With PPG_SAT_FLAG_EN, also flags any 0/255 sample seen in the window.
module ppg_minmax_tracker
    import ppg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             capture_i,
    input  logic [ADC_W-1:0] sample_i,
    output logic [ADC_W-1:0] min_o,
    output logic [ADC_W-1:0] max_o,
    output logic [ADC_W-1:0] ac_o,
    output logic [ADC_W-1:0] dc_o
`ifdef PPG_SAT_FLAG_EN
    ,
    output logic             sat_o
`endif
);

    logic [ADC_W-1:0] min_q, max_q;
    logic [ADC_W-1:0] min_cur, max_cur;
    logic [ADC_W:0]   sum;
    logic             extreme;

    assign extreme = (sample_i == '0) || (sample_i == '1);

    always_comb begin
        min_cur = min_q;
        max_cur = max_q;
        if (capture_i && (sample_i < min_q)) min_cur = sample_i;
        if (capture_i && (sample_i > max_q)) max_cur = sample_i;
    end

    // An empty window leaves max below min; report it as zero rather than wrapping.
    always_comb begin
        sum  = {1'b0, max_cur} + {1'b0, min_cur};
        ac_o = '0;
        dc_o = '0;
        if (max_cur >= min_cur) begin
            ac_o = max_cur - min_cur;
            dc_o = sum[ADC_W:1];
        end
    end

    assign min_o = min_cur;
    assign max_o = max_cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q <= ADC_MIN_INIT;
            max_q <= ADC_MAX_INIT;
        end else if (clear_i) begin
            min_q <= capture_i ? sample_i : ADC_MIN_INIT;
            max_q <= capture_i ? sample_i : ADC_MAX_INIT;
        end else begin
            min_q <= min_cur;
            max_q <= max_cur;
        end
    end

`ifdef PPG_SAT_FLAG_EN
    logic sat_q;

    assign sat_o = sat_q | (capture_i & extreme);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (clear_i) begin
            sat_q <= capture_i & extreme;
        end else begin
            sat_q <= sat_o;
        end
    end
`else
    logic unused_extreme;
    assign unused_extreme = extreme;
`endif

endmodule

// File: rtl/ppg_ac_dc_extractor.sv
// PPG AC/DC extractor: windows RED/IR samples on LED phase falls and reports peak-to-peak and midpoint.
// Define PPG_SAT_FLAG_EN to add per-channel saturation flags.
module ppg_ac_dc_extractor
    import ppg_pkg::*;
#(
    parameter int WINDOW = 100,
    parameter int CNT_W  = 8
)(
    input  logic                  CLK,
    input  logic                  rst_n,
    ppg_ac_dc_extractor_if.slave  bus
);

    localparam int NCH = 2;  // channel 0 = RED, channel 1 = IR

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d, count_inc;
    logic             led_red_q, led_ir_q;
    logic [NCH-1:0]   edge_cap, trk_cap;
    logic             run, trk_clear, report;
    logic             valid_q;

    logic [ADC_W-1:0] smp   [NCH];
    logic [ADC_W-1:0] ac_w  [NCH];
    logic [ADC_W-1:0] dc_w  [NCH];
    logic [ADC_W-1:0] min_w [NCH];
    logic [ADC_W-1:0] max_w [NCH];
    logic [ADC_W-1:0] ac_q  [NCH];
    logic [ADC_W-1:0] dc_q  [NCH];

    assign edge_cap[0] = led_red_q & ~bus.LED_RED;
    assign edge_cap[1] = led_ir_q  & ~bus.LED_IR;
    assign smp[0]      = bus.RED_ADC_Value;
    assign smp[1]      = bus.IR_ADC_Value;

    // REPORT clears the trackers while a same-cycle capture seeds the next window.
    assign run       = bus.Enable && (state_q != IDLE);
    assign trk_cap   = edge_cap & {NCH{run}};
    assign trk_clear = !run || (state_q == REPORT);
    assign count_inc = count_q + 1'b1;

`ifdef PPG_SAT_FLAG_EN
    logic [NCH-1:0] sat_w, sat_q;
`endif

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        ppg_minmax_tracker u_trk (
            .clk       (CLK),
            .rst_n     (rst_n),
            .clear_i   (trk_clear),
            .capture_i (trk_cap[gi]),
            .sample_i  (smp[gi]),
            .min_o     (min_w[gi]),
            .max_o     (max_w[gi]),
            .ac_o      (ac_w[gi]),
            .dc_o      (dc_w[gi])
`ifdef PPG_SAT_FLAG_EN
            ,
            .sat_o     (sat_w[gi])
`endif
        );
    end

    logic unused_minmax;
    assign unused_minmax = ^{min_w[0], max_w[0], min_w[1], max_w[1]};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        report  = 1'b0;
        if (!bus.Enable) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = ACCUM;
                    count_d = '0;
                end
                ACCUM: begin
                    if (edge_cap[1]) begin
                        count_d = count_inc;
                        if (count_inc == CNT_W'(WINDOW)) state_d = REPORT;
                    end
                end
                REPORT: begin
                    report  = 1'b1;
                    state_d = ACCUM;
                    count_d = edge_cap[1] ? CNT_W'(1) : '0;
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            led_red_q <= 1'b0;
            led_ir_q  <= 1'b0;
            valid_q   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                ac_q[i] <= '0;
                dc_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            led_red_q <= bus.LED_RED;
            led_ir_q  <= bus.LED_IR;
            valid_q   <= report;
            if (report) begin
                for (int i = 0; i < NCH; i++) begin
                    ac_q[i] <= ac_w[i];
                    dc_q[i] <= dc_w[i];
                end
            end
        end
    end

`ifdef PPG_SAT_FLAG_EN
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= '0;
        end else if (report) begin
            sat_q <= sat_w;
        end
    end

    assign bus.RED_Sat = sat_q[0];
    assign bus.IR_Sat  = sat_q[1];
`endif

    assign bus.RED_AC       = ac_q[0];
    assign bus.RED_DC       = dc_q[0];
    assign bus.IR_AC        = ac_q[1];
    assign bus.IR_DC        = dc_q[1];
    assign bus.Result_Valid = valid_q;
    assign bus.Pair_Count   = count_q;

endmodule

// File: tb/tb_ppg_ac_dc_extractor.sv
// Scoreboard bench for ppg_ac_dc_extractor: directed windows plus randomized LED/ADC traffic
// checked against a sample-list reference model.
`timescale 1ns/1ps
module tb_ppg_ac_dc_extractor;

    localparam int WINDOW = 4;
    localparam int CNT_W  = 8;

    logic CLK   = 1'b0;
    logic rst_n = 1'b0;
    always #5 CLK = ~CLK;

    ppg_ac_dc_extractor_if #(.CNT_W(CNT_W)) bus ();

    ppg_ac_dc_extractor #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int rac; int rdc; int iac; int idc;
        bit rsat; bit isat;
    } res_t;

    int   checks    = 0;
    int   errors    = 0;
    int   n_results = 0;
    res_t exp_q[$];
    res_t hold = '{0, 0, 0, 0, 1'b0, 1'b0};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: windows as lists of captured samples ----------------
    int red_s[$];
    int ir_s[$];
    bit active     = 0;
    bit rpt_due    = 0;
    bit prev_red   = 0;
    bit prev_ir    = 0;
    bit m_rc, m_ic;
    int pc_exp     = 0;

    function automatic void chan(input int q[$], output int ac, output int dc, output bit sat);
        int mn, mx;
        ac = 0; dc = 0; sat = 0;
        if (q.size() != 0) begin
            mn = 255; mx = 0;
            foreach (q[k]) begin
                if (q[k] < mn) mn = q[k];
                if (q[k] > mx) mx = q[k];
                if (q[k] == 0 || q[k] == 255) sat = 1;
            end
            ac = mx - mn;
            dc = (mx + mn) / 2;
        end
    endfunction

    function automatic res_t summarize(input int rq[$], input int iq[$]);
        res_t r;
        chan(rq, r.rac, r.rdc, r.rsat);
        chan(iq, r.iac, r.idc, r.isat);
        return r;
    endfunction

    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            red_s.delete(); ir_s.delete();
            active = 0; rpt_due = 0; prev_red = 0; prev_ir = 0; pc_exp = 0;
            exp_q.delete();
        end else begin
            m_rc = prev_red && !bus.LED_RED;
            m_ic = prev_ir  && !bus.LED_IR;
            prev_red = bus.LED_RED;
            prev_ir  = bus.LED_IR;
            if (!bus.Enable) begin
                active = 0; rpt_due = 0;
                red_s.delete(); ir_s.delete();
            end else if (!active) begin
                active = 1;
            end else begin
                if (m_rc) red_s.push_back(int'(bus.RED_ADC_Value));
                if (m_ic) ir_s.push_back(int'(bus.IR_ADC_Value));
                if (rpt_due) begin
                    exp_q.push_back(summarize(red_s, ir_s));
                    red_s.delete(); ir_s.delete();
                    if (m_rc) red_s.push_back(int'(bus.RED_ADC_Value));
                    if (m_ic) ir_s.push_back(int'(bus.IR_ADC_Value));
                    rpt_due = 0;
                end else if (ir_s.size() == WINDOW) begin
                    rpt_due = 1;
                end
            end
            pc_exp = ir_s.size();
        end
    end

    // ---------------- monitor: pops on Result_Valid, otherwise outputs must hold ----------------
    always @(negedge CLK) begin
        if (!rst_n) begin
            hold = '{0, 0, 0, 0, 1'b0, 1'b0};
            chk("reset_valid", int'(bus.Result_Valid), 0);
        end else if (bus.Result_Valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", int'(bus.Result_Valid), 0);
            end else begin
                hold = exp_q.pop_front();
                n_results++;
                $display("result %0d: red_ac=%0d red_dc=%0d ir_ac=%0d ir_dc=%0d (expected %0d %0d %0d %0d)",
                         n_results, bus.RED_AC, bus.RED_DC, bus.IR_AC, bus.IR_DC,
                         hold.rac, hold.rdc, hold.iac, hold.idc);
            end
        end
        chk("RED_AC", int'(bus.RED_AC), hold.rac);
        chk("RED_DC", int'(bus.RED_DC), hold.rdc);
        chk("IR_AC",  int'(bus.IR_AC),  hold.iac);
        chk("IR_DC",  int'(bus.IR_DC),  hold.idc);
`ifdef PPG_SAT_FLAG_EN
        chk("RED_Sat", int'(bus.RED_Sat), int'(hold.rsat));
        chk("IR_Sat",  int'(bus.IR_Sat),  int'(hold.isat));
`endif
        chk("Pair_Count", int'(bus.Pair_Count), pc_exp);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_pair(input int r, input int i, input bit use_red);
        bus.LED_RED = use_red;               step();
        bus.LED_RED = 1'b0; bus.RED_ADC_Value = 8'(r); step();
        bus.LED_IR  = 1'b1;                  step();
        bus.LED_IR  = 1'b0; bus.IR_ADC_Value  = 8'(i); step();
    endtask

    task automatic realign();
        bus.Enable = 1'b0; step();
        bus.Enable = 1'b1; step();
    endtask

    // Waits (bounded) for the result strobe, then checks the values the window must produce.
    task automatic expect_result(input string tag, input int rac, input int rdc, input int iac, input int idc);
        bit got;
        got = 0;
        for (int n = 0; n < 8 && !got; n++) begin
            @(negedge CLK);
            if (bus.Result_Valid) got = 1;
        end
        chk({tag, "_valid_seen"}, int'(got), 1);
        if (got) begin
            chk({tag, "_RED_AC"}, int'(bus.RED_AC), rac);
            chk({tag, "_RED_DC"}, int'(bus.RED_DC), rdc);
            chk({tag, "_IR_AC"},  int'(bus.IR_AC),  iac);
            chk({tag, "_IR_DC"},  int'(bus.IR_DC),  idc);
            chk({tag, "_pair_count_zero"}, int'(bus.Pair_Count), 0);
            @(negedge CLK);
            chk({tag, "_valid_one_cycle"}, int'(bus.Result_Valid), 0);
        end
        step();
    endtask

    function automatic int rnd_sample();
        int k;
        k = int'($urandom_range(0, 9));
        if (k == 0) return 0;
        if (k == 1) return 255;
        return int'($urandom_range(0, 255));
    endfunction

    int r1[4] = '{100, 140, 120, 130};
    int i1[4] = '{50, 90, 70, 60};
    int r2[4] = '{255, 254, 255, 254};
    int i2[4] = '{10, 20, 30, 40};
    int i3[4] = '{5, 200, 100, 50};

    initial begin
        bus.Enable = 1'b0; bus.LED_RED = 1'b0; bus.LED_IR = 1'b0;
        bus.RED_ADC_Value = '0; bus.IR_ADC_Value = '0;
        step(); step(); step();
        rst_n = 1'b1;

        // basic window
        realign();
        for (int k = 0; k < 4; k++) do_pair(r1[k], i1[k], 1'b1);
        expect_result("basic", 40, 120, 40, 70);

        // 9-bit DC sum
        realign();
        for (int k = 0; k < 4; k++) do_pair(r2[k], i2[k], 1'b1);
        expect_result("dc_sum9", 1, 254, 30, 25);

        // IR edges only: RED reports zero
        realign();
        for (int k = 0; k < 4; k++) do_pair(0, i3[k], 1'b0);
        expect_result("ir_only", 0, 0, 195, 102);

        // Enable dropped mid-window, then four fresh pairs
        realign();
        do_pair(10, 10, 1'b1); do_pair(250, 250, 1'b1);
        bus.Enable = 1'b0; step(); step(); step();
        bus.Enable = 1'b1; step();
        for (int k = 0; k < 4; k++) do_pair(r1[k], i1[k], 1'b1);
        expect_result("enable_drop", 40, 120, 40, 70);

        // RED falls in the REPORT cycle and seeds the next window
        realign();
        for (int k = 0; k < 3; k++) do_pair(r1[k], i1[k], 1'b1);
        bus.LED_RED = 1'b1; step();
        bus.LED_IR  = 1'b1; step();
        bus.LED_IR  = 1'b0; bus.IR_ADC_Value = 8'd60; step();
        bus.LED_RED = 1'b0; bus.RED_ADC_Value = 8'd77; step();
        for (int k = 0; k < 4; k++) do_pair(200, i2[k], 1'b0);
        step(); step(); step();

        // randomized traffic with occasional Enable drops and one mid-window reset
        for (int c = 0; c < 800; c++) begin
            bus.Enable        = ($urandom_range(0, 99) != 0);
            bus.LED_RED       = 1'($urandom_range(0, 1));
            bus.LED_IR        = 1'($urandom_range(0, 1));
            bus.RED_ADC_Value = 8'(rnd_sample());
            bus.IR_ADC_Value  = 8'(rnd_sample());
            if (c == 400) rst_n = 1'b0;
            if (c == 402) rst_n = 1'b1;
            step();
        end

        bus.Enable = 1'b0; bus.LED_RED = 1'b0; bus.LED_IR = 1'b0;
        repeat (5) step();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
